// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Holds the fetch FSM state encoding and the default parameter values.
package fetch_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_STEP_DEF  = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: taken-branch target has priority over the sequential step,
// otherwise the PC holds. Purely combinational.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            br_valid,
  input  logic            branch,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] branch_offset,
  output logic            taken,
  output logic [XLEN-1:0] next_pc
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] target_s;

  // Branch resolution and next-PC mux; additions wrap modulo 2^XLEN.
  always_comb begin
    taken    = br_valid & branch & alu_zero;
    seq_pc_s = pc + STEP;
    target_s = branch_pc + branch_offset;
    next_pc  = pc;
    if (taken) begin
      next_pc = target_s;
    end else if (advance) begin
      next_pc = seq_pc_s;
    end else begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Sequential instruction-fetch front end: owns the PC, issues one request at a
// time, buffers one instruction for decode and applies taken-branch redirects.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              PC_STEP  = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch,
  input  logic            alu_zero,
  input  logic            br_valid,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] branch_offset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  output logic            redirect
);

  fetch_state_e    state_r;
  logic [XLEN-1:0] pc_r;
  logic            drop_r;
  logic            if_valid_r;
  logic [XLEN-1:0] if_instr_r;
  logic [XLEN-1:0] if_pc_r;
  logic            redirect_r;

  logic            taken_s;
  logic            advance_s;
  logic [XLEN-1:0] next_pc_s;

  // PC steps forward only when a good (non-discarded) response is captured.
  always_comb begin
    advance_s = 1'b0;
    if ((state_r == S_WAIT) && imem_rvalid && !drop_r) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
  end

  pc_next_sel #(
    .XLEN    (XLEN),
    .PC_STEP (PC_STEP)
  ) u_pc_next_sel (
    .pc            (pc_r),
    .advance       (advance_s),
    .br_valid      (br_valid),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .taken         (taken_s),
    .next_pc       (next_pc_s)
  );

  // Fetch FSM, PC register, instruction buffer and redirect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_REQ;
      pc_r       <= RESET_PC;
      drop_r     <= 1'b0;
      if_valid_r <= 1'b0;
      if_instr_r <= '0;
      if_pc_r    <= '0;
      redirect_r <= 1'b0;
    end else begin
      pc_r       <= next_pc_s;
      redirect_r <= taken_s;
      case (state_r)
        S_REQ: begin
          if (imem_gnt) begin
            // A redirect in the grant cycle makes the granted response stale.
            drop_r  <= taken_s;
            state_r <= S_WAIT;
          end else begin
            state_r <= S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_r || taken_s) begin
              drop_r  <= 1'b0;
              state_r <= S_REQ;
            end else begin
              if_instr_r <= imem_rdata;
              if_pc_r    <= pc_r;
              if_valid_r <= 1'b1;
              state_r    <= S_HOLD;
            end
          end else if (taken_s) begin
            drop_r <= 1'b1;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (if_ready || taken_s) begin
            if_valid_r <= 1'b0;
            state_r    <= S_REQ;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          drop_r     <= 1'b0;
          if_valid_r <= 1'b0;
          state_r    <= S_REQ;
        end
      endcase
    end
  end

  assign imem_req  = (state_r == S_REQ) && rst_n;
  assign imem_addr = pc_r;
  assign if_valid  = if_valid_r;
  assign if_instr  = if_instr_r;
  assign if_pc     = if_pc_r;
  assign redirect  = redirect_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: stimulus pushes expected decode-side
// instructions into a scoreboard that a separate monitor drains on handshakes.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, branch, alu_zero, br_valid, imem_gnt, imem_rvalid, if_ready;
  logic [31:0] branch_pc, branch_offset, imem_rdata;
  logic        imem_req, if_valid, redirect;
  logic [31:0] imem_addr, if_instr, if_pc;

  logic        rst2_n, gnt2, rv2, rdy2;
  logic [31:0] rd2;
  logic        req2, v2, redir2;
  logic [31:0] addr2, instr2, pc2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  pc_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .alu_zero(alu_zero),
    .br_valid(br_valid), .branch_pc(branch_pc), .branch_offset(branch_offset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready), .redirect(redirect)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst2_n), .branch(1'b0), .alu_zero(1'b0),
    .br_valid(1'b0), .branch_pc(32'h0), .branch_offset(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rv2), .imem_rdata(rd2), .if_valid(v2),
    .if_instr(instr2), .if_pc(pc2), .if_ready(rdy2), .redirect(redir2)
  );

  // Scoreboard monitor: every decode handshake must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    if (rst_n && if_valid && if_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_instr: got instr %h pc %h, expected no instruction", if_instr, if_pc);
      end else begin
        e = sb_q.pop_front();
        if (if_instr !== e.instr || if_pc !== e.pc) begin
          miscompares++;
          $display("FAIL sb_instr: got instr %h pc %h, expected instr %h pc %h",
                   if_instr, if_pc, e.instr, e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_br(input logic v, input logic b, input logic z,
                        input logic [31:0] bpc, input logic [31:0] off);
    br_valid = v; branch = b; alu_zero = z; branch_pc = bpc; branch_offset = off;
  endtask

  // Request/grant then response; ends at the negedge with the instruction held.
  task automatic do_fetch(input logic [31:0] data, input logic [31:0] addr);
    chk("req_addr", imem_addr, addr);
    chk("req", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = data;
    sb_q.push_back({data, addr});
    cyc();
    imem_rvalid = 1'b0;
    chk("hold_valid", 32'(if_valid), 32'd1);
  endtask

  task automatic fetch_seq(input logic [31:0] data, input logic [31:0] addr);
    do_fetch(data, addr);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b1;
    gnt2 = 1'b0; rv2 = 1'b0; rd2 = 32'h0; rdy2 = 1'b1;
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    cyc();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    cyc();

    // Sequential fetch
    fetch_seq(32'h11, 32'h0);
    fetch_seq(32'h22, 32'h4);
    fetch_seq(32'h33, 32'h8);

    // Backpressure in S_HOLD
    if_ready = 1'b0;
    do_fetch(32'h44, 32'hC);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(if_valid), 32'd1);
      chk("bp_instr", if_instr, 32'h44);
      chk("bp_pc", if_pc, 32'hC);
      chk("bp_noreq", 32'(imem_req), 32'd0);
      cyc();
    end
    if_ready = 1'b1;
    cyc();
    chk("bp_resume_req", 32'(imem_req), 32'd1);
    chk("bp_resume_addr", imem_addr, 32'h10);

    // Taken branch together with the in-flight response
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    set_br(1'b1, 1'b1, 1'b1, 32'h8, 32'h20);
    cyc();
    imem_rvalid = 1'b0;
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("tk_addr", imem_addr, 32'h28);
    chk("tk_req", 32'(imem_req), 32'd1);
    chk("tk_redirect", 32'(redirect), 32'd1);
    chk("tk_novalid", 32'(if_valid), 32'd0);
    cyc();
    chk("tk_redirect_end", 32'(redirect), 32'd0);

    // Taken branch before the response arrives: later response dropped
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    set_br(1'b1, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFF0);
    cyc();
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("drop_redirect", 32'(redirect), 32'd1);
    chk("drop_wait_noreq", 32'(imem_req), 32'd0);
    chk("drop_addr", imem_addr, 32'hF0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    cyc();
    imem_rvalid = 1'b0;
    chk("drop_novalid", 32'(if_valid), 32'd0);
    fetch_seq(32'h55, 32'hF0);

    // Taken branch in S_REQ without a grant
    set_br(1'b1, 1'b1, 1'b1, 32'h200, 32'h4);
    cyc();
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("req_tk_req", 32'(imem_req), 32'd1);
    chk("req_tk_addr", imem_addr, 32'h204);
    chk("req_tk_redirect", 32'(redirect), 32'd1);

    // Not-taken branch: no redirect, sequential flow continues
    set_br(1'b1, 1'b1, 1'b0, 32'h204, 32'h40);
    do_fetch(32'h66, 32'h204);
    chk("nt_redirect", 32'(redirect), 32'd0);
    cyc();
    set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("nt_redirect2", 32'(redirect), 32'd0);
    fetch_seq(32'h77, 32'h208);

    // Reset in the middle of S_WAIT
    chk("mid_addr", imem_addr, 32'h20C);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    chk("mid_wait_noreq", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_instr", if_instr, 32'h0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_req", 32'(imem_req), 32'd1);
    chk("mid_rel_addr", imem_addr, 32'h0);
    cyc();
    fetch_seq(32'h88, 32'h0);

    // PC wrap from 0xFFFF_FFFC
    rst2_n = 1'b1;
    #1;
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    chk("wrap_first_req", 32'(req2), 32'd1);
    cyc();
    gnt2 = 1'b1;
    cyc();
    gnt2 = 1'b0; rv2 = 1'b1; rd2 = 32'h99;
    cyc();
    rv2 = 1'b0;
    chk("wrap_valid", 32'(v2), 32'd1);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_instr", instr2, 32'h99);
    cyc();
    chk("wrap_second_req", 32'(req2), 32'd1);
    chk("wrap_second_addr", addr2, 32'h0);

    cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
